// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle joining the Memory stage, the program loader and the data memory to the arbiter.
// The arbiter takes the slave view; requesters and the memory together take the master view.
interface dmem_port_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic              m_err;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_ack;
  logic              l_err;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic              busy;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  mem_rdata, mem_done,
    output m_ack, m_err, l_ack, l_err, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output mem_rdata, mem_done,
    input  m_ack, m_err, l_ack, l_err, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the Memory stage and the loader/debug port,
// one transaction at a time, with bounds checking and a starvation guard for the loader.
//
// state | meaning
// IDLE  | waiting for a request; grant, latch fields, bounds-check
// BUSY  | mem_en held with latched fields until mem_done
// ACK   | one-cycle ack/err/rdata to the owner; requests ignored
module dmem_port_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int MEM_SIZE   = 1024,
  parameter int STARVE_LIM = 4
) (
  input logic               clk,
  input logic               reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int                CNT_W     = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0]  LIM       = CNT_W'(STARVE_LIM);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 8);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_owner_l;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_en;
  logic              r_busy;
  logic              r_m_ack;
  logic              r_l_ack;
  logic              r_m_err;
  logic              r_l_err;

  logic              w_pick_l;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_addr_bad;

  // Loader wins when alone, or when the Memory stage has used up its consecutive-grant allowance.
  assign w_pick_l    = bus.l_req && (!bus.m_req || (r_starve_cnt == LIM));
  assign w_sel_we    = w_pick_l ? bus.l_we    : bus.m_we;
  assign w_sel_addr  = w_pick_l ? bus.l_addr  : bus.m_addr;
  assign w_sel_wdata = w_pick_l ? bus.l_wdata : bus.m_wdata;
  // Single compare also rejects addresses whose 8-byte span would wrap past 2^64.
  assign w_addr_bad  = w_sel_addr > LAST_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_owner_l    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_mem_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_m_ack      <= 1'b0;
      r_l_ack      <= 1'b0;
      r_m_err      <= 1'b0;
      r_l_err      <= 1'b0;
    end else begin
      r_m_ack <= 1'b0;
      r_l_ack <= 1'b0;
      r_m_err <= 1'b0;
      r_l_err <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (bus.m_req || bus.l_req) begin
            r_owner_l <= w_pick_l;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_busy    <= 1'b1;
            if (w_pick_l || !bus.l_req)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != LIM)
              r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            if (w_addr_bad) begin
              r_state <= ACK;
              r_m_ack <= !w_pick_l;
              r_l_ack <= w_pick_l;
              r_m_err <= !w_pick_l;
              r_l_err <= w_pick_l;
            end else begin
              r_state  <= BUSY;
              r_mem_en <= 1'b1;
            end
          end else begin
            r_starve_cnt <= '0;
          end
        end
        BUSY: begin
          if (bus.mem_done) begin
            r_state  <= ACK;
            r_mem_en <= 1'b0;
            r_m_ack  <= !r_owner_l;
            r_l_ack  <= r_owner_l;
            if (!r_we)
              r_rdata <= bus.mem_rdata;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_mem_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_ack     = r_m_ack;
  assign bus.l_ack     = r_l_ack;
  assign bus.m_err     = r_m_err;
  assign bus.l_err     = r_l_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_we & r_mem_en;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model of the
// arbiter (grant rule, latency rules, bounds check, memory contents).
module tb_dmem_port_arbiter;
  localparam int DW       = 64;
  localparam int AW       = 64;
  localparam int MEM_SIZE = 1024;
  localparam int LIM      = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_SIZE(MEM_SIZE), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // memory responder
  logic [63:0] mem_store [logic [63:0]];
  int mem_wait = 0;
  bit mem_rand = 0;
  int en_cnt = 0;

  // directed-watch results
  int w_mack, w_lack, w_men, w_mack_cyc, w_lack_cyc;
  logic [63:0] w_m_rdata, w_l_rdata, w_addr, w_wdata;
  logic w_m_err, w_l_err, w_we;
  int order [$];

  // transaction-level reference model
  bit pend [2];
  bit p_we [2];
  logic [63:0] p_addr [2];
  logic [63:0] p_wdata [2];
  bit out_active, out_owner, out_we, out_err;
  logic [63:0] out_addr, out_wdata;
  int grant_cyc, done_cyc, idle_from, scnt;
  logic [63:0] ref_mem [logic [63:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_en) begin
      if (mem_rand) bus.mem_done = ($urandom_range(0, 2) == 0);
      else          bus.mem_done = (en_cnt >= mem_wait);
      en_cnt++;
      if (bus.mem_done && !bus.mem_we)
        bus.mem_rdata = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr] : init_word(bus.mem_addr);
      else
        bus.mem_rdata = {$urandom, $urandom};
      if (bus.mem_done && bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
    end else begin
      en_cnt = 0;
      bus.mem_done = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
    end
  endtask

  task automatic drive_port(input int p, input bit req, input bit we, input logic [63:0] a,
                            input logic [63:0] d);
    if (p == 0) begin
      bus.m_req = req; bus.m_we = we; bus.m_addr = a; bus.m_wdata = d;
    end else begin
      bus.l_req = req; bus.l_we = we; bus.l_addr = a; bus.l_wdata = d;
    end
  endtask

  task automatic clr_watch();
    w_mack = 0; w_lack = 0; w_men = 0; w_mack_cyc = -1; w_lack_cyc = -1;
    w_m_rdata = '0; w_l_rdata = '0; w_addr = '0; w_wdata = '0;
    w_m_err = 1'b0; w_l_err = 1'b0; w_we = 1'b0;
    order.delete();
  endtask

  task automatic watch(input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.mem_en) begin
        w_men++; w_addr = bus.mem_addr; w_we = bus.mem_we; w_wdata = bus.mem_wdata;
      end
      if (bus.m_ack) begin
        w_mack++; w_mack_cyc = cyc; w_m_rdata = bus.rdata; w_m_err = bus.m_err;
        order.push_back(0);
        if (!hold) bus.m_req = 1'b0;
      end
      if (bus.l_ack) begin
        w_lack++; w_lack_cyc = cyc; w_l_rdata = bus.rdata; w_l_err = bus.l_err;
        order.push_back(1);
        if (!hold) bus.l_req = 1'b0;
      end
    end
  endtask

  initial begin : main
    int c0;
    logic [63:0] a;
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    bus.mem_done = 1'b0;
    bus.mem_rdata = '0;

    // reset state
    reset = 1'b1;
    step(); step();
    chk("rst_acks", {bus.m_ack, bus.l_ack, bus.m_err, bus.l_err}, 4'b0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem", {bus.mem_en, bus.mem_we, bus.busy}, 3'b0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;
    step();

    // 1: read, memory answers one cycle after mem_en
    mem_wait = 1;
    mem_store[64'h10] = 64'h1122_3344_5566_7788;
    clr_watch();
    drive_port(0, 1, 0, 64'h10, 64'h0);
    c0 = cyc;
    watch(6, 0);
    chk("t1_ack_cnt", w_mack, 1);
    chk("t1_ack_lat", w_mack_cyc - c0, 3);
    chk("t1_rdata", w_m_rdata, 64'h1122_3344_5566_7788);
    chk("t1_err", w_m_err, 0);
    chk("t1_mem_addr", w_addr, 64'h10);
    chk("t1_lack", w_lack, 0);
    chk("t1_busy", bus.busy, 0);

    // 2: loader write, zero-wait memory
    mem_wait = 0;
    clr_watch();
    drive_port(1, 1, 1, 64'h20, 64'hAB);
    c0 = cyc;
    watch(5, 0);
    chk("t2_ack_cnt", w_lack, 1);
    chk("t2_ack_lat", w_lack_cyc - c0, 2);
    chk("t2_mem_we", w_we, 1);
    chk("t2_mem_wdata", w_wdata, 64'hAB);
    chk("t2_mem_addr", w_addr, 64'h20);
    chk("t2_rdata", w_l_rdata, 0);
    chk("t2_mack", w_mack, 0);
    chk("t2_stored", mem_store.exists(64'h20) ? mem_store[64'h20] : 64'hDEAD, 64'hAB);

    // 3: address errors and the last legal address
    clr_watch();
    drive_port(0, 1, 0, 64'h3FC, 64'h0);
    c0 = cyc;
    watch(4, 0);
    chk("t3a_ack_lat", w_mack_cyc - c0, 1);
    chk("t3a_err", w_m_err, 1);
    chk("t3a_mem_en", w_men, 0);
    chk("t3a_rdata", w_m_rdata, 0);
    clr_watch();
    drive_port(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h55);
    c0 = cyc;
    watch(4, 0);
    chk("t3b_ack_lat", w_mack_cyc - c0, 1);
    chk("t3b_err", w_m_err, 1);
    chk("t3b_mem_en", w_men, 0);
    clr_watch();
    drive_port(0, 1, 0, 64'h3F8, 64'h0);
    c0 = cyc;
    watch(4, 0);
    chk("t3c_ack_lat", w_mack_cyc - c0, 2);
    chk("t3c_err", w_m_err, 0);
    chk("t3c_rdata", w_m_rdata, init_word(64'h3F8));

    // 4: continuous contention
    clr_watch();
    drive_port(0, 1, 0, 64'h100, 64'h0);
    drive_port(1, 1, 0, 64'h108, 64'h0);
    watch(30, 1);
    drive_port(0, 0, 0, 64'h0, 64'h0);
    drive_port(1, 0, 0, 64'h0, 64'h0);
    chk("t4_grants", order.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < order.size()) chk($sformatf("t4_order%0d", i), order[i], (i % 5 == 4) ? 1 : 0);
    watch(4, 0);

    // 5: simultaneous single requests, then contention to show the guard restarted from zero
    clr_watch();
    drive_port(0, 1, 0, 64'h200, 64'h0);
    drive_port(1, 1, 0, 64'h208, 64'h0);
    c0 = cyc;
    watch(8, 0);
    chk("t5_grants", order.size(), 2);
    if (order.size() == 2) begin
      chk("t5_first", order[0], 0);
      chk("t5_second", order[1], 1);
    end
    chk("t5_l_lat", w_lack_cyc - c0, 5);
    clr_watch();
    drive_port(0, 1, 0, 64'h100, 64'h0);
    drive_port(1, 1, 0, 64'h108, 64'h0);
    watch(15, 1);
    drive_port(0, 0, 0, 64'h0, 64'h0);
    drive_port(1, 0, 0, 64'h0, 64'h0);
    chk("t5_cont_grants", order.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < order.size()) chk($sformatf("t5_cont%0d", i), order[i], (i == 4) ? 1 : 0);
    watch(4, 0);

    // 6: reset while the memory withholds mem_done
    mem_wait = 1000;
    clr_watch();
    drive_port(0, 1, 0, 64'h40, 64'h0);
    watch(3, 0);
    chk("t6_en_seen", w_men > 0, 1);
    reset = 1'b1;
    drive_port(0, 0, 0, 64'h0, 64'h0);
    step();
    chk("t6_mem_en", bus.mem_en, 0);
    chk("t6_busy", bus.busy, 0);
    reset = 1'b0;
    clr_watch();
    watch(5, 0);
    chk("t6_no_ack", w_mack + w_lack, 0);
    chk("t6_no_en", w_men, 0);
    mem_wait = 0;
    mem_store[64'h48] = 64'hCAFE_F00D_1234_5678;
    clr_watch();
    drive_port(0, 1, 0, 64'h48, 64'h0);
    c0 = cyc;
    watch(5, 0);
    chk("t6_fresh_lat", w_mack_cyc - c0, 2);
    chk("t6_fresh_rdata", w_m_rdata, 64'hCAFE_F00D_1234_5678);

    // randomized run against the reference model
    mem_store.delete();
    ref_mem.delete();
    mem_rand = 1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pend[0] = 0; pend[1] = 0;
    out_active = 0; idle_from = 0; scnt = 0; grant_cyc = 0; done_cyc = -1;
    out_owner = 0; out_we = 0; out_err = 0; out_addr = '0; out_wdata = '0;
    for (int k = 0; k < 4000; k++) begin
      bit ack_due, exp_m, exp_l, exp_en, exp_busy, wl;
      bit obs_ack [2];
      logic [63:0] exp_rd;
      step();
      ack_due  = out_active && (out_err ? (cyc == grant_cyc + 1)
                                        : (done_cyc >= 0 && cyc == done_cyc + 1));
      exp_m    = ack_due && !out_owner;
      exp_l    = ack_due && out_owner;
      exp_en   = out_active && !out_err && (cyc > grant_cyc) && (done_cyc < 0);
      exp_busy = out_active || (cyc < idle_from);
      chk("r_ack", {bus.m_ack, bus.l_ack}, {exp_m, exp_l});
      chk("r_busy", bus.busy, exp_busy);
      chk("r_mem_en", bus.mem_en, exp_en);
      if (exp_en && bus.mem_en) begin
        chk("r_mem_addr", bus.mem_addr, out_addr);
        chk("r_mem_we", bus.mem_we, out_we);
        if (out_we) chk("r_mem_wdata", bus.mem_wdata, out_wdata);
      end
      if (ack_due) begin
        exp_rd = (out_we || out_err) ? 64'h0
               : (ref_mem.exists(out_addr) ? ref_mem[out_addr] : init_word(out_addr));
        chk("r_err", out_owner ? bus.l_err : bus.m_err, out_err);
        chk("r_rdata", bus.rdata, exp_rd);
        if (out_we && !out_err) ref_mem[out_addr] = out_wdata;
        out_active = 0;
        idle_from = cyc + 1;
      end else begin
        chk("r_rdata_idle", bus.rdata, 0);
      end
      if (out_active && !out_err && done_cyc < 0 && bus.mem_done) done_cyc = cyc;

      obs_ack[0] = bus.m_ack;
      obs_ack[1] = bus.l_ack;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && obs_ack[p]) begin
          pend[p] = 0;
          drive_port(p, 0, p_we[p], p_addr[p], p_wdata[p]);
        end
        if (!pend[p] && $urandom_range(0, 99) < 45) begin
          case ($urandom_range(0, 9))
            0:       a = 64'(MEM_SIZE - 8) + 64'($urandom_range(1, 40));
            1:       a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            2:       a = 64'(MEM_SIZE - 8);
            default: a = 64'($urandom_range(0, 127)) * 64'd8;
          endcase
          pend[p] = 1;
          p_we[p] = $urandom_range(0, 1) == 1;
          p_addr[p] = a;
          p_wdata[p] = {$urandom, $urandom};
          drive_port(p, 1, p_we[p], p_addr[p], p_wdata[p]);
        end
      end

      if (!out_active && cyc >= idle_from) begin
        if (pend[0] || pend[1]) begin
          wl = pend[1] && (!pend[0] || scnt == LIM);
          if (wl || !pend[1]) scnt = 0;
          else if (scnt < LIM) scnt++;
          out_owner = wl;
          out_we    = p_we[wl];
          out_addr  = p_addr[wl];
          out_wdata = p_wdata[wl];
          out_err   = out_addr > 64'(MEM_SIZE - 8);
          grant_cyc = cyc;
          done_cyc  = -1;
          out_active = 1;
        end else begin
          scnt = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
